// File: rtl/pll_sequencer_if.sv
// rtl/pll_sequencer_if.sv - control/status bundle between a PLL sequencer and its user
// The sequencer takes the slave side; whoever requests bring-up and watches status takes the master side.
interface pll_sequencer_if;
  logic       enable;
  logic       lock_in;
  logic       pll_resetb;
  logic       pll_bypass;
  logic       clk_ready;
  logic       fault;
  logic [1:0] retries;
  logic [2:0] state;

  modport master (
    output enable,
    output lock_in,
    input  pll_resetb,
    input  pll_bypass,
    input  clk_ready,
    input  fault,
    input  retries,
    input  state
  );

  modport slave (
    input  enable,
    input  lock_in,
    output pll_resetb,
    output pll_bypass,
    output clk_ready,
    output fault,
    output retries,
    output state
  );
endinterface

// File: rtl/pll_sequencer.sv
// rtl/pll_sequencer.sv - PLL reset/lock/stabilise bring-up sequencer with bounded retries
// Define PLL_SEQ_BYPASS_FALLBACK_EN to replace the terminal FAULT state with a bypass FALLBACK state.
module pll_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 12000,
  parameter int STABLE_CYCLES = 1200,
  parameter int MAX_RETRIES   = 3
) (
  input logic              clk,
  input logic              rst,
  pll_sequencer_if.slave   bus
);

`ifdef PLL_SEQ_BYPASS_FALLBACK_EN
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RESET    = 3'd1,
    S_WAIT     = 3'd2,
    S_STABLE   = 3'd3,
    S_RUN      = 3'd4,
    S_FAULT    = 3'd5,
    S_FALLBACK = 3'd6
  } state_e;
  localparam state_e S_GIVE_UP = S_FALLBACK;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RESET  = 3'd1,
    S_WAIT   = 3'd2,
    S_STABLE = 3'd3,
    S_RUN    = 3'd4,
    S_FAULT  = 3'd5
  } state_e;
  localparam state_e S_GIVE_UP = S_FAULT;
`endif

  // Terminal counts: each timed state lasts exactly N cycles, counter runs 0..N-1.
  localparam logic [15:0] RST_LAST    = 16'(RST_CYCLES - 1);
  localparam logic [15:0] LOCK_LAST   = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYCLES - 1);
  localparam logic [1:0]  MAX_R       = 2'(MAX_RETRIES);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  retries_q, retries_d;
  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        pll_resetb_q, pll_resetb_d;
  logic        clk_ready_q, clk_ready_d;
  logic        fault_q, fault_d;
  logic        fail;
  logic        lock_s;

  assign lock_s = sync2_q;

  always_comb begin
    sync1_d   = bus.lock_in;
    sync2_d   = sync1_q;
    state_d   = state_q;
    cnt_d     = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    retries_d = retries_q;
    fail      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.enable) state_d = S_RESET;
      end
      S_RESET: begin
        if (cnt_q == RST_LAST) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (lock_s) state_d = S_STABLE;
        else if (cnt_q == LOCK_LAST) fail = 1'b1;
      end
      S_STABLE: begin
        if (!lock_s) fail = 1'b1;
        else if (cnt_q == STABLE_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        if (!lock_s) fail = 1'b1;
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
`ifdef PLL_SEQ_BYPASS_FALLBACK_EN
      S_FALLBACK: begin
        state_d = S_FALLBACK;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (fail) begin
      if (retries_q < MAX_R) begin
        retries_d = retries_q + 2'd1;
        state_d   = S_RESET;
      end else begin
        state_d = S_GIVE_UP;
      end
    end

    // Dropping enable wins over anything decided above in the same cycle.
    if (!bus.enable) state_d = S_IDLE;

    if (state_d != state_q) cnt_d = 16'd0;
    if (state_d == S_IDLE || state_d == S_RUN) retries_d = 2'd0;

    pll_resetb_d = (state_d == S_WAIT) || (state_d == S_STABLE) || (state_d == S_RUN);
    clk_ready_d  = (state_d == S_RUN);
    fault_d      = (state_d == S_FAULT);
`ifdef PLL_SEQ_BYPASS_FALLBACK_EN
    if (state_d == S_FALLBACK) begin
      pll_resetb_d = 1'b1;
      clk_ready_d  = 1'b1;
      fault_d      = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 16'd0;
      retries_q    <= 2'd0;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      pll_resetb_q <= 1'b0;
      clk_ready_q  <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retries_q    <= retries_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      pll_resetb_q <= pll_resetb_d;
      clk_ready_q  <= clk_ready_d;
      fault_q      <= fault_d;
    end
  end

`ifdef PLL_SEQ_BYPASS_FALLBACK_EN
  logic pll_bypass_q, pll_bypass_d;

  assign pll_bypass_d = (state_d == S_FALLBACK);

  always_ff @(posedge clk) begin
    if (rst) pll_bypass_q <= 1'b0;
    else     pll_bypass_q <= pll_bypass_d;
  end

  assign bus.pll_bypass = pll_bypass_q;
`else
  assign bus.pll_bypass = 1'b0;
`endif

  assign bus.pll_resetb = pll_resetb_q;
  assign bus.clk_ready  = clk_ready_q;
  assign bus.fault      = fault_q;
  assign bus.retries    = retries_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_pll_sequencer.sv
// tb/tb_pll_sequencer.sv - directed bench for pll_sequencer (RST=4, TIMEOUT=20, STABLE=8, RETRIES=2)
module tb_pll_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pll_sequencer_if bus ();

  pll_sequencer #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8),
    .MAX_RETRIES   (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int reset_samples;
    int wait_samples;
    int pulses;
    logic [2:0] prev_state;
    logic ready_seen;

    bus.enable  = 1'b0;
    bus.lock_in = 1'b0;
    step(2);
    check("rst_state",      32'(bus.state),      0);
    check("rst_resetb",     32'(bus.pll_resetb), 0);
    check("rst_bypass",     32'(bus.pll_bypass), 0);
    check("rst_clk_ready",  32'(bus.clk_ready),  0);
    check("rst_fault",      32'(bus.fault),      0);
    check("rst_retries",    32'(bus.retries),    0);
    rst = 1'b0;
    step(1);

    // Clean bring-up: 4-cycle reset pulse, lock 10 cycles after release, ready 11 edges later.
    bus.enable = 1'b1;
    step(1);
    check("a_enter_reset", 32'(bus.state),      1);
    check("a_resetb_low",  32'(bus.pll_resetb), 0);
    n = 0;
    while (bus.pll_resetb !== 1'b1 && n < 50) begin step(1); n++; end
    check("a_reset_len",   32'(n),          4);
    check("a_wait_state",  32'(bus.state),  2);
    step(10);
    bus.lock_in = 1'b1;
    n = 0;
    while (bus.clk_ready !== 1'b1 && n < 40) begin step(1); n++; end
    check("a_ready_edges", 32'(n),              11);
    check("a_run_state",   32'(bus.state),      4);
    check("a_retries",     32'(bus.retries),    0);
    check("a_fault",       32'(bus.fault),      0);
    check("a_bypass",      32'(bus.pll_bypass), 0);

    // Lock loss in RUN: ready drops 3 edges later, one retry, then recovers.
    step(3);
    bus.lock_in = 1'b0;
    n = 0;
    while (bus.clk_ready !== 1'b0 && n < 40) begin step(1); n++; end
    check("c_drop_edges",  32'(n),              3);
    check("c_retries",     32'(bus.retries),    1);
    check("c_state",       32'(bus.state),      1);
    check("c_resetb",      32'(bus.pll_resetb), 0);
    bus.lock_in = 1'b1;
    n = 0;
    while (bus.clk_ready !== 1'b1 && n < 100) begin step(1); n++; end
    check("c_back_ready",   32'(bus.clk_ready), 1);
    check("c_back_state",   32'(bus.state),     4);
    check("c_back_retries", 32'(bus.retries),   0);

    // Reset overrides enable while in RUN.
    rst = 1'b1;
    step(1);
    check("r_state",     32'(bus.state),      0);
    check("r_ready",     32'(bus.clk_ready),  0);
    check("r_resetb",    32'(bus.pll_resetb), 0);
    rst = 1'b0;
    step(1);
    check("r_restart",   32'(bus.state),      1);
    n = 0;
    while (bus.clk_ready !== 1'b1 && n < 100) begin step(1); n++; end
    check("r_run_again", 32'(bus.state),      4);

    // Glitch in STABLE: retry with a fresh 4-cycle pulse, ready never asserts.
    bus.enable = 1'b0;
    step(1);
    check("b_idle",       32'(bus.state),     0);
    check("b_idle_ready", 32'(bus.clk_ready), 0);
    bus.enable = 1'b1;
    n = 0;
    while (bus.state !== 3'd3 && n < 50) begin step(1); n++; end
    check("b_stable", 32'(bus.state), 3);
    step(2);
    bus.lock_in = 1'b0;
    ready_seen  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      ready_seen = ready_seen | bus.clk_ready;
    end
    bus.lock_in = 1'b1;
    check("b_retry_state", 32'(bus.state),   1);
    check("b_retries",     32'(bus.retries), 1);
    n = 0;
    while (bus.pll_resetb !== 1'b1 && n < 50) begin
      step(1);
      n++;
      ready_seen = ready_seen | bus.clk_ready;
    end
    check("b_reset_len",  32'(n),          4);
    check("b_ready_low",  32'(ready_seen), 0);
    n = 0;
    while (bus.clk_ready !== 1'b1 && n < 100) begin step(1); n++; end
    check("b_recover_retries", 32'(bus.retries), 0);

    // Lock never arrives: three pulses of 4, three waits of 20, then give up.
    bus.enable  = 1'b0;
    bus.lock_in = 1'b0;
    step(3);
    check("d_idle", 32'(bus.state), 0);
    bus.enable    = 1'b1;
    reset_samples = 0;
    wait_samples  = 0;
    pulses        = 0;
    prev_state    = 3'd0;
    n = 0;
    while (bus.state !== 3'd5 && bus.state !== 3'd6 && n < 300) begin
      step(1);
      n++;
      if (bus.state == 3'd1) reset_samples++;
      if (bus.state == 3'd2) wait_samples++;
      if (bus.state == 3'd1 && prev_state != 3'd1) pulses++;
      prev_state = bus.state;
    end
    check("d_pulses",        32'(pulses),        3);
    check("d_reset_cycles",  32'(reset_samples), 12);
    check("d_wait_cycles",   32'(wait_samples),  60);
    check("d_retries",       32'(bus.retries),   2);
    check("d_fault",         32'(bus.fault),     1);
`ifdef PLL_SEQ_BYPASS_FALLBACK_EN
    check("d_state",         32'(bus.state),      6);
    check("d_bypass",        32'(bus.pll_bypass), 1);
    check("d_ready",         32'(bus.clk_ready),  1);
    check("d_resetb",        32'(bus.pll_resetb), 1);
    step(5);
    check("d_hold_state",    32'(bus.state),      6);
`else
    check("d_state",         32'(bus.state),      5);
    check("d_bypass",        32'(bus.pll_bypass), 0);
    check("d_ready",         32'(bus.clk_ready),  0);
    check("d_resetb",        32'(bus.pll_resetb), 0);
    step(5);
    check("d_hold_state",    32'(bus.state),      5);
`endif
    check("d_hold_fault",    32'(bus.fault),      1);
    bus.enable = 1'b0;
    step(1);
    check("d_exit_state",    32'(bus.state),      0);
    check("d_exit_fault",    32'(bus.fault),      0);
    check("d_exit_retries",  32'(bus.retries),    0);
    check("d_exit_bypass",   32'(bus.pll_bypass), 0);

    // Enable drops on the exact edge the final timeout would fire.
    bus.enable = 1'b1;
    n = 0;
    while (!(bus.state == 3'd2 && bus.retries == 2'd2) && n < 200) begin step(1); n++; end
    check("e_last_wait", 32'(bus.state), 2);
    step(19);
    check("e_pre_timeout", 32'(bus.state), 2);
    bus.enable = 1'b0;
    step(1);
    check("e_state",   32'(bus.state),      0);
    check("e_fault",   32'(bus.fault),      0);
    check("e_retries", 32'(bus.retries),    0);
    check("e_resetb",  32'(bus.pll_resetb), 0);
    check("e_bypass",  32'(bus.pll_bypass), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pll_sequencer.md
PLL_SEQUENCER -- requirements
Module: pll_sequencer

Interface
REQ-001 Parameter RST_CYCLES, default 16, SHALL set the number of clk cycles pll_resetb is held low per reset pulse (range 1..255).
REQ-002 Parameter LOCK_TIMEOUT, default 12000, SHALL set the number of WAIT_LOCK cycles before a lock attempt is declared failed (1 ms at 12 MHz; range 2..65535).
REQ-003 Parameter STABLE_CYCLES, default 1200, SHALL set the number of consecutive cycles synchronized lock must be high before release (range 1..65535).
REQ-004 Parameter MAX_RETRIES, default 3, SHALL set the number of re-attempts after the first failure (range 0..3).
REQ-005 clk  in  1  reference clock, never the PLL output.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 enable  in  1  level request to bring the PLL up; low forces shutdown.
REQ-008 lock_in  in  1  PLL LOCK, asynchronous to clk.
REQ-009 pll_resetb  out  1  to PLL RESETB, active low.
REQ-010 pll_bypass  out  1  to PLL BYPASS.
REQ-011 clk_ready  out  1  PLL output usable by downstream logic.
REQ-012 fault  out  1  bring-up failed.
REQ-013 retries  out  2  failed attempts since last IDLE or RUN entry.
REQ-014 state  out  3  IDLE=0, RESET=1, WAIT_LOCK=2, STABLE=3, RUN=4, FAULT=5, FALLBACK=6.

Function
REQ-015 lock_in SHALL pass through a 2-flop synchronizer; lock_s is its output; all decisions use lock_s only.
REQ-016 All outputs SHALL be registered; each takes its new value on the edge that enters the new state.
REQ-017 IDLE: pll_resetb=0, clk_ready=0, fault=0, retries=0; enable=1 -> RESET.
REQ-018 RESET: pll_resetb=0 for exactly RST_CYCLES cycles, then -> WAIT_LOCK with pll_resetb=1.
REQ-019 WAIT_LOCK: lock_s=1 -> STABLE; LOCK_TIMEOUT cycles elapsed without lock_s -> failure path.
REQ-020 STABLE: STABLE_CYCLES consecutive cycles of lock_s=1 -> RUN; any lock_s=0 -> failure path.
REQ-021 RUN: clk_ready=1, retries cleared to 0; lock_s=0 -> failure path with clk_ready=0 on the same edge.
REQ-022 Failure path: retries<MAX_RETRIES -> retries+1, -> RESET; else -> FAULT (retries holds).
REQ-023 FAULT: fault=1, pll_resetb=0, clk_ready=0; held until enable=0.
REQ-024 enable=0 in any state SHALL force IDLE on the next edge, with priority over timeout, lock change and failure path occurring in the same cycle.
REQ-025 Counters SHALL saturate, never wrap, and SHALL clear on every state change.
REQ-026 pll_bypass SHALL be 0 in every state except FALLBACK.

Reset
REQ-027 rst=1 at a clk edge SHALL force state=IDLE, counters=0, synchronizer flops=0, pll_resetb=0, pll_bypass=0, clk_ready=0, fault=0, retries=0, regardless of the current state; rst has priority over enable.

Configuration
REQ-028 Macro PLL_SEQ_BYPASS_FALLBACK_EN defined: the failure path SHALL enter FALLBACK instead of FAULT, with pll_bypass=1, pll_resetb=1, clk_ready=1, fault=1; exit only via enable=0 or rst.
REQ-029 Macro undefined: FALLBACK SHALL not exist, state never equals 6, and pll_bypass SHALL be constant 0.

Verification (RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2)
REQ-030 Enable at cycle 0, lock_in rises 10 cycles after pll_resetb rises -> pll_resetb low 4 cycles; clk_ready=1 11 edges after lock_in rises; retries=0; state=4.
REQ-031 lock_in held 0 -> three 4-cycle reset pulses, each followed by 20 WAIT_LOCK cycles; then fault=1, retries=2, state=5, pll_resetb=0.
REQ-032 lock_in low for 3 cycles during STABLE -> retries=1, new 4-cycle reset pulse, clk_ready stays 0.
REQ-033 In RUN, lock_in falls -> clk_ready=0 3 edges later, retries=1; lock_in returns -> clk_ready=1 again with retries=0.
REQ-034 enable falls on the same cycle the WAIT_LOCK timeout expires -> next state IDLE, fault=0, retries=0, pll_resetb=0.
REQ-035 With PLL_SEQ_BYPASS_FALLBACK_EN, scenario REQ-031 -> state=6, pll_bypass=1, clk_ready=1, fault=1; enable=0 -> IDLE with pll_bypass=0.
